ahb_dw64_to_dw32_bridge: RTL and testbench
==========================================

Name: ahb_dw64_to_dw32_bridge

Overview:
- AHB-lite 64-bit slave to 32-bit AHB-lite master downsizer.
- Sits directly downstream of the two-master 64-bit AHB-lite multiplexer that merges the core's IFU and LSU ports.
- Converts each 64-bit (HSIZE=3) access into two 32-bit NONSEQ beats and passes narrower accesses through as one beat.
- Gives the core access to 32-bit peripherals and memories.

Parameters:
- AW, 32, address width on both sides.

Ports:
- HCLK  in  1  system clock
- HRESET  in  1  synchronous active-high reset
- HSEL  in  1  slave select
- HADDR  in  AW  upstream address
- HTRANS  in  2  upstream transfer type
- HWRITE  in  1  upstream write
- HSIZE  in  3  upstream size
- HWDATA  in  64  upstream write data
- HREADY  in  1  upstream bus ready (the mux's HREADY input; equals HREADYOUT in a single-slave system)
- HREADYOUT  out  1  upstream ready
- HRDATA  out  64  upstream read data
- HRESP  out  1  upstream error response
- HADDR_M  out  AW  downstream address
- HTRANS_M  out  2  downstream transfer type
- HWRITE_M  out  1  downstream write
- HSIZE_M  out  3  downstream size
- HWDATA_M  out  32  downstream write data
- HRDATA_M  in  32  downstream read data
- HREADY_M  in  1  downstream ready
- HRESP_M  in  1  downstream error

Behaviour:
- Reset values (sync, HRESET=1 at a rising edge): state=IDLE; HREADYOUT=1; HRESP=0; HRDATA=0; HTRANS_M=00; HADDR_M=0; HWRITE_M=0; HSIZE_M=0; HWDATA_M=0; err flag=0.
- Accept condition: HSEL & HTRANS[1] & HREADY. SEQ is treated as NONSEQ; IDLE and BUSY are ignored.
- On accept, latch HADDR, HWRITE and HSIZE, clear err, go to A0.
- States:
  - IDLE: HREADYOUT=1, HRESP=0. On accept go to A0.
  - A0:
    - HREADYOUT=0.
    - Capture HWDATA into a 64-bit wdata register every cycle (upstream data phase).
    - Drive HTRANS_M=10 and HWRITE_M=latched write.
    - Size 3: HADDR_M={addr[AW-1:3],000}, HSIZE_M=010. Address bits [2:0] are ignored.
    - Size 0-2: HADDR_M=addr, HSIZE_M=size.
    - Hold until HREADY_M=1, then go to D0A1 (size 3) or D0 (otherwise).
  - D0A1:
    - Beat-0 data phase: HWDATA_M=wdata[31:0].
    - Beat-1 address phase: HADDR_M={addr[AW-1:3],100}, HTRANS_M=10, HSIZE_M=010.
    - Hold all outputs until HREADY_M=1.
    - On HREADY_M=1: rdata[31:0]<=HRDATA_M, err|=HRESP_M, go to D1.
  - D1:
    - HTRANS_M=00, HWDATA_M=wdata[63:32].
    - On HREADY_M=1: rdata[63:32]<=HRDATA_M, err|=HRESP_M, go to DONE.
  - D0:
    - HTRANS_M=00, HWDATA_M = addr[2] ? wdata[63:32] : wdata[31:0].
    - On HREADY_M=1: rdata<={HRDATA_M,HRDATA_M}, err|=HRESP_M, go to DONE (err=0) or ERR1 (err=1).
  - DONE (err=0): HREADYOUT=1, HRDATA=rdata. On accept go to A0, else IDLE.
  - ERR1: HREADYOUT=0, HRESP=1, go to ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. On accept go to A0, else IDLE.
  - D1 exits to ERR1 instead of DONE when err=1.
- Error on beat 0 of a double: beat 1 still completes (its address was already issued). Error is reported once via the two-cycle response.
- HADDR_M, HWRITE_M and HSIZE_M hold their last values while HTRANS_M=00.
- HRDATA holds rdata in all states.
- Latency with zero-wait downstream: single access 3 cycles of upstream data phase (A0, D0, DONE); double access 4 cycles (A0, D0A1, D1, DONE). Each downstream wait cycle adds one cycle.
- Back-to-back accesses: acceptance in DONE/ERR2 enters A0 with no idle bubble.
- Reset mid-operation: state returns to IDLE at the reset edge and HTRANS_M=00 from the next cycle. The in-flight downstream transfer is abandoned and no upstream response is given.

Test Plan:
- Double read at 0x100 (HSIZE=3), downstream returns 0x11111111 then 0x22222222 with zero wait -> HADDR_M 0x100 then 0x104, HSIZE_M=2; HRDATA=0x22222222_11111111 with HREADYOUT=1 on the 4th data-phase cycle.
- Double write at 0x208, HWDATA=0xAAAA5555_12345678 -> beats at 0x208/0x20C; HWDATA_M 0x12345678 then 0xAAAA5555; HWRITE_M=1.
- Word read at 0x304 (HSIZE=2), HRDATA_M=0xCAFEF00D, HREADY_M low 2 cycles in D0 -> HRDATA=0xCAFEF00D_CAFEF00D; data phase lasts 5 cycles.
- Byte write at 0x405, HWDATA upper lane 0x000000EF_xxxxxxxx -> one beat, HADDR_M=0x405, HSIZE_M=0, HWDATA_M=0x000000EF.
- Double read with HRESP_M=1 on beat 0 -> beat 1 still issued at +4; upstream sees HRESP=1/HREADYOUT=0, then HRESP=1/HREADYOUT=1, then IDLE.
- HRESET asserted in D0A1 -> next cycle HTRANS_M=00, HREADYOUT=1, HRDATA=0; a subsequent word read completes normally.

Source files
------------

// File: rtl/ahb_dw64_to_dw32_bridge.sv
// AHB-lite 64-bit slave to 32-bit AHB-lite master downsizer.
// 64-bit accesses become two 32-bit NONSEQ beats; narrower accesses pass through as one beat.
module ahb_dw64_to_dw32_bridge #(
    parameter int AW = 32
) (
    input  logic          HCLK,
    input  logic          HRESET,
    input  logic          HSEL,
    input  logic [AW-1:0] HADDR,
    input  logic [1:0]    HTRANS,
    input  logic          HWRITE,
    input  logic [2:0]    HSIZE,
    input  logic [63:0]   HWDATA,
    input  logic          HREADY,
    output logic          HREADYOUT,
    output logic [63:0]   HRDATA,
    output logic          HRESP,
    output logic [AW-1:0] HADDR_M,
    output logic [1:0]    HTRANS_M,
    output logic          HWRITE_M,
    output logic [2:0]    HSIZE_M,
    output logic [31:0]   HWDATA_M,
    input  logic [31:0]   HRDATA_M,
    input  logic          HREADY_M,
    input  logic          HRESP_M,
    output logic [2:0]    dbg_state
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_A0, ST_D0A1, ST_D1, ST_D0, ST_DONE, ST_ERR1, ST_ERR2
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q;
    logic          write_q;
    logic [2:0]    size_q;
    logic [63:0]   wdata_q;
    logic [63:0]   rdata_q;
    logic          err_q;
    logic [AW-1:0] last_addr_q;
    logic          last_write_q;
    logic [2:0]    last_size_q;
    logic [31:0]   last_wdata_q;
    logic          accept;
    logic          take;
    logic          dbl;
    logic          err_any;
    logic          unused_htrans0;

    // SEQ is treated as NONSEQ, so only HTRANS[1] matters.
    assign accept         = HSEL & HTRANS[1] & HREADY;
    assign dbl            = (size_q == 3'd3);
    assign err_any        = err_q | HRESP_M;
    assign unused_htrans0 = HTRANS[0];
    assign HRDATA         = rdata_q;
    assign dbg_state      = state_q;

    // Downstream address/control hold their last driven values whenever HTRANS_M is IDLE.
    always_comb begin
        state_d   = state_q;
        take      = 1'b0;
        HREADYOUT = 1'b0;
        HRESP     = 1'b0;
        HTRANS_M  = 2'b00;
        HADDR_M   = last_addr_q;
        HWRITE_M  = last_write_q;
        HSIZE_M   = last_size_q;
        HWDATA_M  = last_wdata_q;
        case (state_q)
            ST_IDLE: begin
                HREADYOUT = 1'b1;
                take      = accept;
                if (accept) state_d = ST_A0;
            end
            ST_A0: begin
                HTRANS_M = 2'b10;
                HWRITE_M = write_q;
                HADDR_M  = dbl ? {addr_q[AW-1:3], 3'b000} : addr_q;
                HSIZE_M  = dbl ? 3'b010 : size_q;
                if (HREADY_M) state_d = dbl ? ST_D0A1 : ST_D0;
            end
            ST_D0A1: begin
                HWDATA_M = wdata_q[31:0];
                HTRANS_M = 2'b10;
                HWRITE_M = write_q;
                HADDR_M  = {addr_q[AW-1:3], 3'b100};
                HSIZE_M  = 3'b010;
                if (HREADY_M) state_d = ST_D1;
            end
            ST_D1: begin
                HWDATA_M = wdata_q[63:32];
                if (HREADY_M) state_d = err_any ? ST_ERR1 : ST_DONE;
            end
            ST_D0: begin
                HWDATA_M = addr_q[2] ? wdata_q[63:32] : wdata_q[31:0];
                if (HREADY_M) state_d = err_any ? ST_ERR1 : ST_DONE;
            end
            ST_DONE: begin
                HREADYOUT = 1'b1;
                take      = accept;
                state_d   = accept ? ST_A0 : ST_IDLE;
            end
            ST_ERR1: begin
                HRESP   = 1'b1;
                state_d = ST_ERR2;
            end
            ST_ERR2: begin
                HREADYOUT = 1'b1;
                HRESP     = 1'b1;
                take      = accept;
                state_d   = accept ? ST_A0 : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            write_q      <= 1'b0;
            size_q       <= 3'd0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            last_addr_q  <= '0;
            last_write_q <= 1'b0;
            last_size_q  <= 3'd0;
            last_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            last_addr_q  <= HADDR_M;
            last_write_q <= HWRITE_M;
            last_size_q  <= HSIZE_M;
            last_wdata_q <= HWDATA_M;
            if (take) begin
                addr_q  <= HADDR;
                write_q <= HWRITE;
                size_q  <= HSIZE;
                err_q   <= 1'b0;
            end
            // A0 is the upstream data phase, so HWDATA is sampled there until the beat is issued.
            case (state_q)
                ST_A0: wdata_q <= HWDATA;
                ST_D0A1: if (HREADY_M) begin
                    rdata_q[31:0] <= HRDATA_M;
                    err_q         <= err_any;
                end
                ST_D1: if (HREADY_M) begin
                    rdata_q[63:32] <= HRDATA_M;
                    err_q          <= err_any;
                end
                ST_D0: if (HREADY_M) begin
                    rdata_q <= {HRDATA_M, HRDATA_M};
                    err_q   <= err_any;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_dw64_to_dw32_bridge.sv
// Bench for ahb_dw64_to_dw32_bridge: upstream master driver, reactive 32-bit slave,
// beat scoreboard against a transaction-level model.
module tb_ahb_dw64_to_dw32_bridge;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic        HSEL = 1'b0;
    logic [31:0] HADDR = '0;
    logic [1:0]  HTRANS = 2'b00;
    logic        HWRITE = 1'b0;
    logic [2:0]  HSIZE = 3'd0;
    logic [63:0] HWDATA = '0;
    logic        HREADY;
    logic        HREADYOUT;
    logic [63:0] HRDATA;
    logic        HRESP;
    logic [31:0] HADDR_M;
    logic [1:0]  HTRANS_M;
    logic        HWRITE_M;
    logic [2:0]  HSIZE_M;
    logic [31:0] HWDATA_M;
    logic [31:0] HRDATA_M = '0;
    logic        HREADY_M = 1'b1;
    logic        HRESP_M = 1'b0;
    logic [2:0]  unused_dbg_state;
    logic        hready_low = 1'b0;

    assign HREADY = hready_low ? 1'b0 : HREADYOUT;

    ahb_dw64_to_dw32_bridge #(.AW(32)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
        .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP),
        .HADDR_M(HADDR_M), .HTRANS_M(HTRANS_M), .HWRITE_M(HWRITE_M), .HSIZE_M(HSIZE_M),
        .HWDATA_M(HWDATA_M), .HRDATA_M(HRDATA_M), .HREADY_M(HREADY_M), .HRESP_M(HRESP_M),
        .dbg_state(unused_dbg_state)
    );

    // clock / reset
    always #5 HCLK = ~HCLK;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  size;
        logic        write;
        logic [63:0] wdata;
        int          w0;
        int          w1;
        bit          e0;
        bit          e1;
        bit          seq;
    } txn_t;

    txn_t        tl[$];
    // beat = {addr[31:0], size[2:0], write, wdata[31:0]}
    logic [67:0] exp_q[$];
    logic [67:0] obs_q[$];
    logic [63:0] r_rdata[$];
    bit          r_resp[$];
    bit          r_e1[$];
    int          r_cyc[$];
    logic [31:0] mem [logic [31:0]];
    int          wait_q[$];
    bit          errc_q[$];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        logic [31:0] k;
        k = {a[31:2], 2'b00};
        if (mem.exists(k)) return mem[k];
        return k ^ 32'hA5C3_96E1;
    endfunction

    // downstream slave: decides HREADY_M/HRESP_M/HRDATA_M mid-cycle for the coming edge
    bit          dp_active = 1'b0;
    logic [31:0] dp_addr = '0;
    logic [2:0]  dp_size = '0;
    logic        dp_write = 1'b0;
    int          dp_wait = 0;
    bit          dp_err = 1'b0;

    always @(negedge HCLK) begin
        if (HRESET) begin
            HREADY_M  = 1'b1;
            HRESP_M   = 1'b0;
            dp_active = 1'b0;
        end else begin
            if (dp_active && dp_wait > 0) begin
                HREADY_M = 1'b0;
                HRESP_M  = 1'b0;
                HRDATA_M = $urandom;
                dp_wait  = dp_wait - 1;
            end else if (dp_active) begin
                HREADY_M = 1'b1;
                HRESP_M  = dp_err;
                HRDATA_M = mem_rd(dp_addr);
                obs_q.push_back({dp_addr, dp_size, dp_write, HWDATA_M});
                dp_active = 1'b0;
            end else begin
                HREADY_M = 1'b1;
                HRESP_M  = 1'b0;
                HRDATA_M = $urandom;
            end
            if (HREADY_M && HTRANS_M[1]) begin
                dp_active = 1'b1;
                dp_addr   = HADDR_M;
                dp_size   = HSIZE_M;
                dp_write  = HWRITE_M;
                dp_wait   = 0;
                dp_err    = 1'b0;
                if (wait_q.size() > 0) dp_wait = wait_q.pop_front();
                if (errc_q.size() > 0) dp_err = errc_q.pop_front();
            end
        end
    end

    // transaction-level model of the downstream beats a transfer must produce
    function automatic void model_push(input txn_t t);
        logic [31:0] b;
        b = {t.addr[31:3], 3'b000};
        if (t.size == 3'd3) begin
            exp_q.push_back({b, 3'd2, t.write, t.wdata[31:0]});
            exp_q.push_back({b + 32'd4, 3'd2, t.write, t.wdata[63:32]});
        end else begin
            exp_q.push_back({t.addr, t.size, t.write, t.addr[2] ? t.wdata[63:32] : t.wdata[31:0]});
        end
    endfunction

    function automatic txn_t mk(input logic [31:0] a, input logic [2:0] s, input logic w,
                                input logic [63:0] d, input int w0, input int w1,
                                input bit e0, input bit e1);
        txn_t t;
        t.addr = a; t.size = s; t.write = w; t.wdata = d;
        t.w0 = w0; t.w1 = w1; t.e0 = e0; t.e1 = e1; t.seq = 1'b0;
        return t;
    endfunction

    function automatic txn_t rnd_txn();
        txn_t t;
        t.size = 3'($urandom_range(0, 3));
        t.addr = $urandom_range(0, 32'hFFFF);
        if (t.size == 3'd1) t.addr[0] = 1'b0;
        if (t.size == 3'd2) t.addr[1:0] = 2'b00;
        t.write = 1'($urandom_range(0, 1));
        t.wdata = {$urandom, $urandom};
        t.w0 = $urandom_range(0, 3);
        t.w1 = $urandom_range(0, 3);
        t.e0 = ($urandom_range(0, 7) == 0);
        t.e1 = ($urandom_range(0, 7) == 0);
        t.seq = 1'($urandom_range(0, 1));
        return t;
    endfunction

    // driver + scoreboard: issues tl[] upstream, collects responses, checks against the model
    task automatic run_list(input bit b2b);
        int n, ia, cur, nxt, cyc, guard;
        bit saw_e1, done_now, dbl, err;
        logic [31:0] b;
        logic [63:0] exp_rd;
        int exp_cyc;
        n = tl.size(); ia = 0; cur = -1; nxt = -1; cyc = 0; guard = 0; saw_e1 = 0;
        exp_q.delete(); obs_q.delete(); wait_q.delete(); errc_q.delete();
        r_rdata.delete(); r_resp.delete(); r_e1.delete(); r_cyc.delete();
        foreach (tl[i]) begin
            model_push(tl[i]);
            wait_q.push_back(tl[i].w0);
            errc_q.push_back(tl[i].e0);
            if (tl[i].size == 3'd3) begin
                wait_q.push_back(tl[i].w1);
                errc_q.push_back(tl[i].e1);
            end
        end
        while ((ia < n || cur >= 0 || nxt >= 0) && guard < 20 + 30 * n) begin
            @(posedge HCLK); #1;
            guard++;
            if (nxt >= 0) begin cur = nxt; nxt = -1; cyc = 0; saw_e1 = 0; end
            done_now = 1'b0;
            if (cur >= 0) begin
                cyc++;
                if (!HREADYOUT && HRESP) saw_e1 = 1'b1;
                if (HREADYOUT) begin
                    r_rdata.push_back(HRDATA); r_resp.push_back(HRESP);
                    r_e1.push_back(saw_e1); r_cyc.push_back(cyc);
                    cur = -1; done_now = 1'b1;
                end
            end
            HWDATA = (cur >= 0) ? tl[cur].wdata : {$urandom, $urandom};
            if (HREADYOUT && ia < n && (b2b || !done_now)) begin
                HSEL = 1'b1; HTRANS = tl[ia].seq ? 2'b11 : 2'b10;
                HADDR = tl[ia].addr; HWRITE = tl[ia].write; HSIZE = tl[ia].size;
                nxt = ia; ia++;
            end else begin
                HSEL = 1'($urandom_range(0, 1)); HTRANS = 2'($urandom_range(0, 1));
                HADDR = $urandom; HWRITE = 1'($urandom_range(0, 1)); HSIZE = 3'($urandom_range(0, 7));
            end
        end
        HSEL = 1'b0; HTRANS = 2'b00;
        n_checks++;
        if (r_cyc.size() != n) begin
            n_fail++;
            $display("FAIL run_list_timeout: completed %0d of %0d transfers", r_cyc.size(), n);
        end
        foreach (r_cyc[i]) begin
            dbl = (tl[i].size == 3'd3);
            err = tl[i].e0 | (dbl & tl[i].e1);
            b = {tl[i].addr[31:3], 3'b000};
            exp_rd = dbl ? {mem_rd(b + 32'd4), mem_rd(b)} : {2{mem_rd(tl[i].addr)}};
            exp_cyc = (dbl ? 4 + tl[i].w0 + tl[i].w1 : 3 + tl[i].w0) + (err ? 1 : 0);
            n_checks++;
            if (r_cyc[i] !== exp_cyc) begin
                n_fail++; $display("FAIL txn%0d_cycles: got %0d exp %0d", i, r_cyc[i], exp_cyc);
            end
            n_checks++;
            if (r_resp[i] !== err || r_e1[i] !== err) begin
                n_fail++; $display("FAIL txn%0d_resp: got resp=%0d err1=%0d exp %0d", i, r_resp[i], r_e1[i], err);
            end
            n_checks++;
            if (r_rdata[i] !== exp_rd) begin
                n_fail++; $display("FAIL txn%0d_rdata: got %h exp %h", i, r_rdata[i], exp_rd);
            end
        end
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL beat_count: got %0d exp %0d", obs_q.size(), exp_q.size());
        end
        foreach (obs_q[i]) begin
            if (i < exp_q.size()) begin
                n_checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL beat%0d: got %h exp %h", i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        HRESET = 1'b1;
        repeat (2) @(posedge HCLK);
        #1;
        n_checks += 8;
        if (HREADYOUT !== 1'b1) begin n_fail++; $display("FAIL rst_hreadyout: got %b exp 1", HREADYOUT); end
        if (HRESP !== 1'b0) begin n_fail++; $display("FAIL rst_hresp: got %b exp 0", HRESP); end
        if (HRDATA !== 64'd0) begin n_fail++; $display("FAIL rst_hrdata: got %h exp 0", HRDATA); end
        if (HTRANS_M !== 2'b00) begin n_fail++; $display("FAIL rst_htrans_m: got %b exp 00", HTRANS_M); end
        if (HADDR_M !== 32'd0) begin n_fail++; $display("FAIL rst_haddr_m: got %h exp 0", HADDR_M); end
        if (HWRITE_M !== 1'b0) begin n_fail++; $display("FAIL rst_hwrite_m: got %b exp 0", HWRITE_M); end
        if (HSIZE_M !== 3'd0) begin n_fail++; $display("FAIL rst_hsize_m: got %0d exp 0", HSIZE_M); end
        if (HWDATA_M !== 32'd0) begin n_fail++; $display("FAIL rst_hwdata_m: got %h exp 0", HWDATA_M); end
        HRESET = 1'b0;
    endtask

    task automatic test_double_read();
        mem[32'h100] = 32'h1111_1111;
        mem[32'h104] = 32'h2222_2222;
        tl.delete();
        tl.push_back(mk(32'h100, 3'd3, 1'b0, {$urandom, $urandom}, 0, 0, 0, 0));
        run_list(1'b0);
        n_checks += 2;
        if (r_rdata.size() != 1 || r_rdata[0] !== 64'h2222_2222_1111_1111 || r_cyc[0] != 4) begin
            n_fail++; $display("FAIL dread_data: got %h after %0d cycles exp 2222222211111111 after 4", HRDATA, r_cyc.size() > 0 ? r_cyc[0] : -1);
        end
        if (obs_q.size() != 2 || obs_q[0][67:33] !== {32'h100, 3'd2} || obs_q[1][67:33] !== {32'h104, 3'd2}) begin
            n_fail++; $display("FAIL dread_beats: got %0d beats exp 0x100/0x104 size 2", obs_q.size());
        end
    endtask

    task automatic test_double_write();
        tl.delete();
        tl.push_back(mk(32'h208, 3'd3, 1'b1, 64'hAAAA_5555_1234_5678, 0, 0, 0, 0));
        run_list(1'b0);
        n_checks++;
        if (obs_q.size() != 2 || obs_q[0] !== {32'h208, 3'd2, 1'b1, 32'h1234_5678}
            || obs_q[1] !== {32'h20C, 3'd2, 1'b1, 32'hAAAA_5555}) begin
            n_fail++; $display("FAIL dwrite_beats: got %0d beats first %h exp 208/20C 12345678/AAAA5555",
                               obs_q.size(), obs_q.size() > 0 ? obs_q[0] : 68'd0);
        end
    endtask

    task automatic test_word_wait();
        mem[32'h304] = 32'hCAFE_F00D;
        tl.delete();
        tl.push_back(mk(32'h304, 3'd2, 1'b0, {$urandom, $urandom}, 2, 0, 0, 0));
        run_list(1'b0);
        n_checks++;
        if (r_rdata.size() != 1 || r_rdata[0] !== 64'hCAFE_F00D_CAFE_F00D || r_cyc[0] != 5) begin
            n_fail++; $display("FAIL word_wait: got %h exp CAFEF00DCAFEF00D in 5 cycles", HRDATA);
        end
    endtask

    task automatic test_byte_write();
        tl.delete();
        tl.push_back(mk(32'h405, 3'd0, 1'b1, {32'h0000_00EF, $urandom}, 0, 0, 0, 0));
        run_list(1'b0);
        n_checks++;
        if (obs_q.size() != 1 || obs_q[0] !== {32'h405, 3'd0, 1'b1, 32'h0000_00EF}) begin
            n_fail++; $display("FAIL byte_write: got %0d beats first %h exp 405/0/1/000000EF",
                               obs_q.size(), obs_q.size() > 0 ? obs_q[0] : 68'd0);
        end
    endtask

    task automatic test_error();
        tl.delete();
        tl.push_back(mk(32'h500, 3'd3, 1'b0, {$urandom, $urandom}, 0, 0, 1, 0));
        run_list(1'b0);
        n_checks++;
        if (obs_q.size() != 2 || obs_q[1][67:36] !== 32'h504) begin
            n_fail++; $display("FAIL err_beat1: got %0d beats exp second beat at 504", obs_q.size());
        end
        @(posedge HCLK); #1;
        n_checks += 2;
        if (HREADYOUT !== 1'b1 || HRESP !== 1'b0 || HTRANS_M !== 2'b00) begin
            n_fail++; $display("FAIL err_idle: got rdy=%b resp=%b trans=%b exp 1/0/00", HREADYOUT, HRESP, HTRANS_M);
        end
        if (HADDR_M !== 32'h504) begin
            n_fail++; $display("FAIL addr_hold: got %h exp 504", HADDR_M);
        end
    endtask

    task automatic test_ignored();
        for (int k = 0; k < 4; k++) begin
            @(posedge HCLK); #1;
            HSEL = (k != 0); HTRANS = (k == 1) ? 2'b00 : (k == 2) ? 2'b01 : 2'b10;
            hready_low = (k == 3); HADDR = 32'h700; HSIZE = 3'd2; HWRITE = 1'b0;
            @(posedge HCLK); #1;
            hready_low = 1'b0; HSEL = 1'b0; HTRANS = 2'b00;
            n_checks++;
            if (HREADYOUT !== 1'b1 || HTRANS_M !== 2'b00) begin
                n_fail++; $display("FAIL ignored_%0d: got rdy=%b trans=%b exp 1/00", k, HREADYOUT, HTRANS_M);
            end
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        guard = 0;
        exp_q.delete(); obs_q.delete(); wait_q.delete(); errc_q.delete();
        @(posedge HCLK); #1;
        while (!HREADYOUT && guard < 20) begin @(posedge HCLK); #1; guard++; end
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h600; HWRITE = 1'b0; HSIZE = 3'd3;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = {$urandom, $urandom};
        @(posedge HCLK); #1;
        n_checks++;
        if (HTRANS_M !== 2'b10 || HADDR_M !== 32'h604) begin
            n_fail++; $display("FAIL rmid_beat1: got trans=%b addr=%h exp 10/604", HTRANS_M, HADDR_M);
        end
        HRESET = 1'b1;
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        n_checks += 2;
        if (HTRANS_M !== 2'b00 || HREADYOUT !== 1'b1 || HRDATA !== 64'd0) begin
            n_fail++; $display("FAIL rmid_state: got trans=%b rdy=%b rdata=%h exp 00/1/0", HTRANS_M, HREADYOUT, HRDATA);
        end
        if (HADDR_M !== 32'd0) begin
            n_fail++; $display("FAIL rmid_addr: got %h exp 0", HADDR_M);
        end
        mem[32'h610] = 32'h0BAD_BEEF;
        tl.delete();
        tl.push_back(mk(32'h610, 3'd2, 1'b0, {$urandom, $urandom}, 0, 0, 0, 0));
        run_list(1'b0);
        n_checks++;
        if (r_rdata.size() != 1 || r_rdata[0] !== 64'h0BAD_BEEF_0BAD_BEEF) begin
            n_fail++; $display("FAIL rmid_after: got %h exp 0BADBEEF0BADBEEF", HRDATA);
        end
    endtask

    task automatic test_back_to_back();
        tl.delete();
        for (int i = 0; i < 6; i++) begin
            txn_t t;
            t = rnd_txn();
            t.w0 = 0; t.w1 = 0; t.e0 = (i == 2); t.e1 = 1'b0;
            tl.push_back(t);
        end
        run_list(1'b1);
    endtask

    task automatic test_random();
        for (int r = 0; r < 5; r++) begin
            tl.delete();
            for (int i = 0; i < 10; i++) tl.push_back(rnd_txn());
            run_list(1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_double_read();
        test_double_write();
        test_word_wait();
        test_byte_write();
        test_error();
        test_ignored();
        test_reset_mid();
        test_back_to_back();
        test_random();
        repeat (3) @(posedge HCLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
